erasable_core_resp: RTL and testbench
=====================================

# erasable_core_resp

Behavioural responder for one erasable core-memory bank. It is the far end of the G-register sense/write-back path driven by the four-bit arithmetic slices. It performs the destructive read cycle: selects a word, clears it, and presents the sensed value on the sense-amp bus (SA). It then waits for the write-back (GEM) and restores the word. The block replaces ideal memory in full-system benches so that sense-amp timing, destructive-read and rewrite ordering are exercised.

## Interface
Parameters:
- ADDR_W, 11, erasable address width (2048 words)
- READ_DELAY, 2, cycles from cycle-start accept to sense strobe (min 1)
- REWRITE_TIMEOUT, 8, cycles allowed in WAITWB before the rewrite is abandoned (min 1)

Ports:
- CLOCK  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- SETEK  in  1  erasable cycle start; sampled only in IDLE
- EAD  in  ADDR_W  word address; captured with SETEK
- WEG  in  1  write-back strobe; GEM valid this cycle
- GEM  in  16  write-back data; bits 15:1 data, bit 16 parity
- SA  out  16  sense-amp bus; zero except on the sense cycle
- SA_VLD  out  1  one-cycle strobe marking SA valid
- EBUSY  out  1  high from accept until write-back completes
- PARALM  out  1  one-cycle parity alarm coincident with SA_VLD
- CYCERR  out  1  one-cycle protocol error pulse

## Operation
- Storage: 2^ADDR_W words of 16 bits. Contents are not affected by rst.
- State machine:
  - IDLE: SETEK=1 → capture EAD into addr_q and load the delay counter with READ_DELAY → READ. EBUSY rises the same edge.
  - READ: count down. On the edge where the count reaches 0, latch mem[addr_q] into sense_q, write mem[addr_q]=0 (destructive read), and go to SENSE.
  - SENSE: one cycle. SA=sense_q and SA_VLD=1. Load the timeout counter with REWRITE_TIMEOUT → WAITWB.
  - WAITWB: WEG=1 → mem[addr_q]=GEM, then → IDLE. If the timeout reaches 0 without WEG, pulse CYCERR, leave the word at 0, and → IDLE.
- SETEK while not in IDLE: ignored for sequencing; pulses CYCERR for one cycle.
- WEG outside WAITWB: ignored; pulses CYCERR; memory unchanged.
- WEG on the same cycle as the timeout expiry: the write wins and CYCERR stays low.
- Simultaneous errors in one cycle produce a single CYCERR pulse.
- Address wrap: not applicable. EAD is exactly ADDR_W bits, and every value is a valid word.

## Timing
- Reset values: state=IDLE, SA=0, SA_VLD=0, EBUSY=0, PARALM=0, CYCERR=0, counters=0.
- SETEK accepted at edge N. SA_VLD is high during the cycle following edge N+READ_DELAY+1.
- Earliest write-back: the cycle after SA_VLD. Earliest next accept: the cycle after the write-back edge.
- EBUSY falls on the edge that performs the write-back or the timeout.
- Back-to-back minimum: a cycle every READ_DELAY+3 clocks.
- SA, SA_VLD, PARALM and CYCERR are registered; no combinational path from inputs.
- rst mid-cycle: returns to IDLE next edge and drops all outputs. If the destructive clear already happened, the word stays 0 and no write-back occurs. This models power interruption.

## Configuration
- EMEM_PARITY_EN defined:
  - On write-back, bit 16 is stored as supplied.
  - On sense, PARALM=1 with SA_VLD when bits 16:1 of the sensed word have even weight. Odd parity is required.
  - SA bit 16 carries the stored bit.
- EMEM_PARITY_EN undefined:
  - Bit 16 is stored as 0 and SA bit 16 is always 0.
  - PARALM is tied to 0.
  - No parity logic is present.

## Test plan
- Reset, then mem[0x005] preloaded 16'h8001. Pulse SETEK with EAD=5 → SA=16'h8001 and SA_VLD on the 4th cycle after accept (READ_DELAY=2). mem[5] reads 0 before any WEG. Then WEG with GEM=16'h0123 → mem[5]=16'h0123 and EBUSY falls.
- No WEG after the sense → CYCERR pulses exactly REWRITE_TIMEOUT=8 cycles after SA_VLD and mem[5]=0. The next SETEK is accepted normally.
- SETEK during READ and WEG during IDLE → one CYCERR pulse each, with no change to state or memory.
- rst asserted the cycle after SA_VLD → all outputs 0 next cycle and the word stays 0. A following cycle to the same address senses 16'h0000.
- With EMEM_PARITY_EN: sense word 16'h0003 → PARALM=1 with SA_VLD. Sense word 16'h8003 → PARALM=0. Without the macro, both cases give PARALM=0 and SA bit 16=0.
- Back-to-back cycles to addresses 0x7FF and 0x000 at the minimum spacing (5 clocks) → both sense correctly, with no CYCERR.

Source files
------------

// File: rtl/erasable_core_resp.sv
// erasable_core_resp: destructive-read erasable core bank responder.
// Define EMEM_PARITY_EN to store bit 16 and raise PARALM on even-weight words.
module erasable_core_resp #(
    parameter int ADDR_W          = 11,
    parameter int READ_DELAY      = 2,
    parameter int REWRITE_TIMEOUT = 8
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              SETEK,
    input  logic [ADDR_W-1:0] EAD,
    input  logic              WEG,
    input  logic [15:0]       GEM,
    output logic [15:0]       SA,
    output logic              SA_VLD,
    output logic              EBUSY,
    output logic              PARALM,
    output logic              CYCERR
);

    localparam int DW = $clog2(READ_DELAY + 1);
    localparam int TW = $clog2(REWRITE_TIMEOUT + 1);

`ifdef EMEM_PARITY_EN
    localparam logic [15:0] WORD_MASK = 16'hFFFF;
`else
    localparam logic [15:0] WORD_MASK = 16'h7FFF;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SENSE  = 2'd2,
        WAITWB = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       sense_q, sense_d;
    logic [15:0]       sa_q, sa_d;
    logic              sa_vld_q, sa_vld_d;
    logic              ebusy_q, ebusy_d;
    logic              paralm_q, paralm_d;
    logic              cycerr_q, cycerr_d;

    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic              timeout;

    logic [15:0] mem [2**ADDR_W];

    // State and datapath registers
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            tcnt_q   <= '0;
            addr_q   <= '0;
            sense_q  <= '0;
            sa_q     <= '0;
            sa_vld_q <= 1'b0;
            ebusy_q  <= 1'b0;
            paralm_q <= 1'b0;
            cycerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            tcnt_q   <= tcnt_d;
            addr_q   <= addr_d;
            sense_q  <= sense_d;
            sa_q     <= sa_d;
            sa_vld_q <= sa_vld_d;
            ebusy_q  <= ebusy_d;
            paralm_q <= paralm_d;
            cycerr_q <= cycerr_d;
        end
    end

    // Core contents survive reset; a reset edge suppresses any pending write
    always_ff @(posedge CLOCK) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= mem_wdata;
        end
    end

    // Next-state and memory sequencing
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        tcnt_d    = tcnt_q;
        addr_d    = addr_q;
        sense_d   = sense_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        timeout   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SETEK) begin
                    state_d = READ;
                    addr_d  = EAD;
                    dcnt_d  = DW'(READ_DELAY);
                end
            end
            READ: begin
                dcnt_d = dcnt_q - DW'(1);
                if (dcnt_q == DW'(1)) begin
                    sense_d = mem[addr_q];
                    mem_we  = 1'b1;
                    state_d = SENSE;
                end
            end
            SENSE: begin
                tcnt_d  = TW'(REWRITE_TIMEOUT);
                state_d = WAITWB;
            end
            WAITWB: begin
                tcnt_d = tcnt_q - TW'(1);
                if (WEG) begin
                    mem_we    = 1'b1;
                    mem_wdata = GEM & WORD_MASK;
                    tcnt_d    = '0;
                    state_d   = IDLE;
                end else if (tcnt_q == TW'(1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered output values
    always_comb begin
        sa_d     = '0;
        sa_vld_d = 1'b0;
        paralm_d = 1'b0;
        ebusy_d  = (state_d != IDLE);
        cycerr_d = (SETEK && state_q != IDLE)
                 | (WEG && state_q != WAITWB)
                 | timeout;
        if (state_q == SENSE) begin
            sa_d     = sense_q & WORD_MASK;
            sa_vld_d = 1'b1;
`ifdef EMEM_PARITY_EN
            paralm_d = ~^sense_q;
`endif
        end
    end

    assign SA     = sa_q;
    assign SA_VLD = sa_vld_q;
    assign EBUSY  = ebusy_q;
    assign PARALM = paralm_q;
    assign CYCERR = cycerr_q;

endmodule

// File: tb/tb_erasable_core_resp.sv
// tb_erasable_core_resp: directed plus randomized checks of the core bank
// against an associative-array memory model with protocol timing rules.
module tb_erasable_core_resp;

    localparam int AW = 11;
    localparam int RD = 2;
    localparam int TO = 8;

`ifdef EMEM_PARITY_EN
    localparam logic [15:0] MASK   = 16'hFFFF;
    localparam logic        PAR_EN = 1'b1;
`else
    localparam logic [15:0] MASK   = 16'h7FFF;
    localparam logic        PAR_EN = 1'b0;
`endif

    logic          CLOCK = 1'b0;
    logic          rst = 1'b1;
    logic          SETEK = 1'b0;
    logic [AW-1:0] EAD = '0;
    logic          WEG = 1'b0;
    logic [15:0]   GEM = '0;
    logic [15:0]   SA;
    logic          SA_VLD;
    logic          EBUSY;
    logic          PARALM;
    logic          CYCERR;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [int];

    erasable_core_resp #(
        .ADDR_W(AW),
        .READ_DELAY(RD),
        .REWRITE_TIMEOUT(TO)
    ) dut (
        .CLOCK(CLOCK),
        .rst(rst),
        .SETEK(SETEK),
        .EAD(EAD),
        .WEG(WEG),
        .GEM(GEM),
        .SA(SA),
        .SA_VLD(SA_VLD),
        .EBUSY(EBUSY),
        .PARALM(PARALM),
        .CYCERR(CYCERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_par(input logic [15:0] w);
        return (~^w) & PAR_EN;
    endfunction

    function automatic logic [15:0] mem_at(input int a);
        logic [AW-1:0] ai;
        ai = a[AW-1:0];
        return dut.mem[ai];
    endfunction

    // wb: waiting cycles before WEG (0..TO-1), negative means no write-back.
    // err: 1 = SETEK during READ, 2 = SETEK and WEG together during READ.
    task automatic do_cycle(input int a, input logic [15:0] g, input int wb,
                            input int err, input bit rst_after);
        bit          known;
        logic [15:0] e;
        known = mdl.exists(a);
        e = known ? mdl[a] : 16'h0;
        SETEK = 1'b1;
        EAD = a[AW-1:0];
        tick();
        chk("ebusy_rise", EBUSY, 1);
        chk("sa_vld_early", SA_VLD, 0);
        SETEK = (err != 0);
        WEG = (err == 2);
        GEM = 16'hFFFF;
        for (int k = 1; k <= RD; k++) begin
            tick();
            SETEK = 1'b0;
            WEG = 1'b0;
            chk("cycerr_read", CYCERR, (k == 1) && (err != 0));
            chk("sa_vld_read", SA_VLD, 0);
            chk("ebusy_read", EBUSY, 1);
        end
        tick();
        chk("sa_vld", SA_VLD, 1);
        chk("cycerr_sense", CYCERR, 0);
        if (known) begin
            chk("sa_data", SA, e);
            chk("paralm", PARALM, exp_par(e));
        end
        chk("destructive_clear", mem_at(a), 16'h0);
        mdl[a] = 16'h0;
        if (rst_after) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_sa", SA, 0);
            chk("rst_sa_vld", SA_VLD, 0);
            chk("rst_ebusy", EBUSY, 0);
            chk("rst_paralm", PARALM, 0);
            chk("rst_cycerr", CYCERR, 0);
            chk("rst_mem", mem_at(a), 16'h0);
            return;
        end
        if (wb >= 0 && wb < TO) begin
            for (int j = 0; j < wb; j++) begin
                tick();
                chk("cycerr_wait", CYCERR, 0);
                chk("ebusy_wait", EBUSY, 1);
                chk("sa_after", SA, 0);
            end
            WEG = 1'b1;
            GEM = g;
            tick();
            WEG = 1'b0;
            mdl[a] = g & MASK;
            chk("ebusy_fall_wb", EBUSY, 0);
            chk("cycerr_wb", CYCERR, 0);
            chk("wb_mem", mem_at(a), mdl[a]);
        end else begin
            for (int j = 0; j < TO - 1; j++) begin
                tick();
                chk("cycerr_wait_to", CYCERR, 0);
                chk("ebusy_wait_to", EBUSY, 1);
            end
            tick();
            chk("cycerr_timeout", CYCERR, 1);
            chk("ebusy_fall_to", EBUSY, 0);
            chk("timeout_mem", mem_at(a), 16'h0);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_sa", SA, 0);
        chk("reset_sa_vld", SA_VLD, 0);
        chk("reset_ebusy", EBUSY, 0);
        chk("reset_paralm", PARALM, 0);
        chk("reset_cycerr", CYCERR, 0);

        // Preload word 5, then basic read / rewrite
        do_cycle(5, 16'h8001, 0, 0, 1'b0);
        do_cycle(5, 16'h0123, 0, 0, 1'b0);
        do_cycle(5, 16'h0123, 2, 0, 1'b0);

        // No write-back: timeout leaves word cleared, next accept normal
        do_cycle(5, 16'h0456, -1, 0, 1'b0);
        do_cycle(5, 16'h0777, 3, 1, 1'b0);

        // Stray write-back in IDLE
        WEG = 1'b1;
        GEM = 16'hFFFF;
        tick();
        WEG = 1'b0;
        chk("cycerr_weg_idle", CYCERR, 1);
        chk("ebusy_weg_idle", EBUSY, 0);
        chk("mem_weg_idle", mem_at(5), mdl[5]);
        tick();
        chk("cycerr_weg_idle_end", CYCERR, 0);

        // Combined errors give one pulse; reset after sense keeps zero
        do_cycle(5, 16'h0999, 0, 2, 1'b0);
        do_cycle(5, 16'h0000, 0, 0, 1'b1);
        do_cycle(5, 16'h1111, 0, 0, 1'b0);

        // Write on the final allowed cycle beats the timeout
        do_cycle(5, 16'h2222, TO - 1, 0, 1'b0);
        do_cycle(5, 16'h3333, 0, 0, 1'b0);

        // Parity words
        do_cycle(16, 16'h0003, 0, 0, 1'b0);
        do_cycle(17, 16'h8003, 0, 0, 1'b0);
        do_cycle(16, 16'h0003, 0, 0, 1'b0);
        do_cycle(17, 16'h8003, 0, 0, 1'b0);

        // Address extremes at minimum spacing
        do_cycle(2047, 16'hA5A5, 0, 0, 1'b0);
        do_cycle(0, 16'h5A5A, 0, 0, 1'b0);
        do_cycle(2047, 16'h1234, 0, 0, 1'b0);
        do_cycle(0, 16'h4321, 0, 0, 1'b0);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 40; i++) begin
            int          a;
            int          w;
            int          er;
            logic [15:0] g;
            a = int'($urandom_range(0, 7));
            g = 16'($urandom);
            w = int'($urandom_range(0, TO));
            if (w == TO) w = -1;
            er = int'($urandom_range(0, 5));
            if (er > 2) er = 0;
            do_cycle(a, g, w, er, ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
